int_to_float8: RTL and testbench

- Sequential converter from unsigned integer to the team's 8-bit float format: {exp[2:0], man[4:0]}, value = man × 2^exp.
- Sits directly upstream of the float adder and produces its aIn/bIn operands.
- Normalizes by shifting one bit per cycle.
- Truncates (rounds toward zero), saturates to 8'hFF, and flags saturation and inexact results.

---
 rtl/int_to_float8.sv | 115 +++++++++++
 tb/tb_int_to_float8.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/int_to_float8.sv
// Unsigned integer to float8 {exp[2:0], man[4:0]} converter, value = man * 2^exp.
// Normalizes one bit per cycle, truncates toward zero, saturates to 8'hFF.
module int_to_float8 #(
    parameter int IN_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic            out_sat,
    output logic            out_inexact
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IN_W-1:0] work_q, work_d;
    logic [2:0]      exp_q, exp_d;
    logic            sticky_q, sticky_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_sat_q, out_sat_d;
    logic            out_inexact_q, out_inexact_d;

    // Mantissa fits once nothing remains above bit 4; stays valid for IN_W == 5.
    logic [IN_W-1:0] work_hi;
    logic            work_fits;
    assign work_hi   = work_q >> 5;
    assign work_fits = (work_hi == '0);

    always_comb begin
        state_d       = state_q;
        work_d        = work_q;
        exp_d         = exp_q;
        sticky_d      = sticky_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_sat_d     = out_sat_q;
        out_inexact_d = out_inexact_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d   = in_data;
                    exp_d    = 3'd0;
                    sticky_d = 1'b0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (work_fits) begin
                    out_data_d    = {exp_q, work_q[4:0]};
                    out_inexact_d = sticky_q;
                    out_sat_d     = 1'b0;
                    out_valid_d   = 1'b1;
                    state_d       = S_DONE;
                end else if (exp_q == 3'd7) begin
                    // Saturation is tested before the increment so exp never wraps.
                    out_data_d    = 8'hFF;
                    out_sat_d     = 1'b1;
                    out_inexact_d = 1'b0;
                    out_valid_d   = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    sticky_d = sticky_q | work_q[0];
                    work_d   = work_q >> 1;
                    exp_d    = exp_q + 3'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            work_q        <= '0;
            exp_q         <= 3'd0;
            sticky_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 8'h00;
            out_sat_q     <= 1'b0;
            out_inexact_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            work_q        <= work_d;
            exp_q         <= exp_d;
            sticky_q      <= sticky_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sat_q     <= out_sat_d;
            out_inexact_q <= out_inexact_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sat     = out_sat_q;
    assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_int_to_float8.sv
// Scoreboard bench for int_to_float8: expected results are queued at drive time
// and compared against what the converter presents.
module tb_int_to_float8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sat;
    logic        out_inexact;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] data;
        logic       sat;
        logic       inx;
        int         lat;
    } exp_t;

    exp_t sb[$];

    int_to_float8 #(.IN_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    // Reference: smallest exponent whose quotient fits five bits, remainder sets inexact.
    function automatic exp_t model(input int unsigned v);
        exp_t r;
        r.data = 8'hFF; r.sat = 1'b1; r.inx = 1'b0; r.lat = 8;
        for (int e = 0; e < 8; e++) begin
            int unsigned q;
            q = v >> e;
            if (q < 32) begin
                r.data = {e[2:0], q[4:0]};
                r.sat  = 1'b0;
                r.inx  = ((v & ((32'd1 << e) - 1)) != 0);
                r.lat  = e + 1;
                break;
            end
        end
        return r;
    endfunction

    task automatic run_one(input int unsigned v, output logic [7:0] d, output logic s,
                           output logic x, output int lat, output bit to);
        @(negedge clk);
        in_data  = v[15:0];
        in_valid = 1'b1;
        sb.push_back(model(v));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        to  = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                to  = 1'b0;
                break;
            end
        end
        d = out_data; s = out_sat; x = out_inexact;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", out_data); end
        checks++; if (out_sat !== 1'b0 || out_inexact !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b want=00", out_sat, out_inexact); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_convert(input int unsigned v, input string nm);
        logic [7:0] d; logic s, x; int lat; bit to; exp_t e;
        run_one(v, d, s, x, lat, to);
        e = sb.pop_front();
        checks++;
        if (to) begin errors++; $display("FAIL %s_timeout no out_valid within 20 cycles", nm); end
        else begin
            if (d !== e.data) begin errors++; $display("FAIL %s_data got=%h want=%h", nm, d, e.data); end
            checks++; if (s !== e.sat) begin errors++; $display("FAIL %s_sat got=%b want=%b", nm, s, e.sat); end
            checks++; if (x !== e.inx) begin errors++; $display("FAIL %s_inexact got=%b want=%b", nm, x, e.inx); end
            checks++; if (lat != e.lat) begin errors++; $display("FAIL %s_latency got=%0d want=%0d", nm, lat, e.lat); end
        end
        ack();
    endtask

    task automatic test_basic();
        test_convert(0, "zero");
        test_convert(20, "v20");
        test_convert(100, "v100");
        test_convert(101, "v101");
    endtask

    task automatic test_saturation();
        test_convert(3968, "v3968");
        test_convert(3969, "v3969");
        test_convert(4095, "v4095");
        test_convert(4096, "v4096");
        test_convert(16'hFFFF, "vFFFF");
    endtask

    task automatic test_backpressure();
        logic [7:0] d; logic s, x; int lat; bit to; exp_t e; bit bad;
        run_one(101, d, s, x, lat, to);
        e = sb.pop_front();
        checks++;
        if (to || d !== e.data || x !== e.inx) begin
            errors++; $display("FAIL bp_result got=%h/%b want=%h/%b", d, x, e.data, e.inx);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 16'd7;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_data !== d || out_inexact !== x || out_sat !== s || in_ready !== 1'b0)
                bad = 1'b1;
        end
        in_valid = 1'b0;
        checks++; if (bad) begin errors++; $display("FAIL bp_hold got=%b%h%b want=1%h0", out_valid, out_data, in_ready, d); end
        ack();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got=valid%b ready%b want=valid0 ready1", out_valid, in_ready);
        end
        // Ignored in_valid pulses must not have queued a conversion of 7.
        test_convert(64, "bp_next");
    endtask

    task automatic test_reset_abort();
        bit seen;
        @(negedge clk);
        in_data = 16'd1000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_premature got=%b want=0", out_valid); end
        rst = 1'b1; #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_clear got=v%b d%h r%b want=v0 d00 r1", out_valid, out_data, in_ready);
        end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL abort_emitted got=1 want=0"); end
        test_convert(1000, "v1000");
    endtask

    task automatic test_back_to_back();
        int unsigned vals[$];
        logic [7:0] d; logic s, x; int lat; bit to; exp_t e;
        vals = '{0, 31, 32, 64, 65535};
        for (int i = 0; i < 6; i++) vals.push_back($urandom_range(0, 65535));
        out_ready = 1'b1;
        foreach (vals[i]) begin
            run_one(vals[i], d, s, x, lat, to);
            e = sb.pop_front();
            checks++;
            if (to || d !== e.data || s !== e.sat || x !== e.inx || lat != e.lat) begin
                errors++;
                $display("FAIL b2b_%0d in=%0d got=%h s%b x%b l%0d want=%h s%b x%b l%0d",
                         i, vals[i], d, s, x, lat, e.data, e.sat, e.inx, e.lat);
            end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low_%0d got=%b want=0", i, in_ready); end
            @(posedge clk); #1;
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL b2b_ready_rise_%0d got=r%b v%b want=r1 v0", i, in_ready, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
